// File: rtl/cla_16b.sv
// 16-bit two-level carry-lookahead adder with one register stage on sum/carry-out.
// Four 4-bit lookahead groups feed a second-level carry unit; no inter-group ripple.
module cla_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CI,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] S,
  output logic        CO
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [15:0] w_sum;
  logic [3:0]  w_pg;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;  // carries into each group; w_gc[4] is c16

  logic [15:0] r_sum;
  logic        r_co;

  assign w_g = A & B;
  assign w_p = A ^ B;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_group
      logic g0, g1, g2, g3;
      logic p0, p1, p2, p3;
      logic c0;

      assign g0 = w_g[4*gi];
      assign g1 = w_g[4*gi+1];
      assign g2 = w_g[4*gi+2];
      assign g3 = w_g[4*gi+3];
      assign p0 = w_p[4*gi];
      assign p1 = w_p[4*gi+1];
      assign p2 = w_p[4*gi+2];
      assign p3 = w_p[4*gi+3];
      assign c0 = w_gc[gi];

      // In-group carries are flattened so each depends only on the group carry-in.
      assign w_c[4*gi]   = c0;
      assign w_c[4*gi+1] = g0 | (p0 & c0);
      assign w_c[4*gi+2] = g1 | (p1 & g0) | (p1 & p0 & c0);
      assign w_c[4*gi+3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & c0);

      assign w_pg[gi] = p3 & p2 & p1 & p0;
      assign w_gg[gi] = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
    end
  endgenerate

  assign w_gc[0] = CI;
  assign w_gc[1] = w_gg[0] | (w_pg[0] & CI);
  assign w_gc[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & CI);
  assign w_gc[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & CI);
  assign w_gc[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & CI);

  assign w_sum = w_p ^ w_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= 16'h0000;
      r_co  <= 1'b0;
    end else begin
      r_sum <= w_sum;
      r_co  <= w_gc[4];
    end
  end

  assign S  = r_sum;
  assign CO = r_co;

endmodule

// File: tb/tb_cla_16b.sv
// Directed and randomised checks of cla_16b against hand-computed and 17-bit reference sums.
module tb_cla_16b;

  logic        clk;
  logic        rst_n;
  logic        CI;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] S;
  logic        CO;

  int n_vec;
  int n_err;

  cla_16b dut (
    .clk  (clk),
    .rst_n(rst_n),
    .CI   (CI),
    .A    (A),
    .B    (B),
    .S    (S),
    .CO   (CO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 16'h1234; B = 16'h1111; CI = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (S !== 16'h0000 || CO !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got S=%h CO=%b, want S=0000 CO=0", i, S, CO);
      end
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (S !== 16'h2346 || CO !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got S=%h CO=%b, want S=2346 CO=0", S, CO);
    end
    $display("reset: release result S=%h CO=%b", S, CO);
  endtask

  task automatic test_small_sums();
    logic [15:0] ta [9] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd3, 16'd7, 16'd3,  16'd14, 16'd15};
    logic [15:0] tb [9] = '{16'd0, 16'd0, 16'd1, 16'd3, 16'd3, 16'd3, 16'd12, 16'd1,  16'd15};
    logic [15:0] ts [9] = '{16'd0, 16'd1, 16'd3, 16'd5, 16'd6, 16'd10, 16'd15, 16'd15, 16'd30};
    for (int i = 0; i < 9; i++) begin
      A = ta[i]; B = tb[i]; CI = 1'b0;
      step();
      n_vec++;
      if (S !== ts[i] || CO !== 1'b0) begin
        n_err++;
        $display("FAIL small_sum %0d+%0d: got S=%0d CO=%b, want S=%0d CO=0",
                 ta[i], tb[i], S, CO, ts[i]);
      end
      $display("small: %0d + %0d -> S=%0d CO=%b", ta[i], tb[i], S, CO);
    end
  endtask

  task automatic test_full_carry();
    logic [15:0] ta [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0000, 16'h0001, 16'hFFFF};
    logic        tc [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ts [3] = '{16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      A = ta[i]; B = tb[i]; CI = tc[i];
      step();
      n_vec++;
      if (S !== ts[i] || CO !== 1'b1) begin
        n_err++;
        $display("FAIL full_carry %h+%h+%b: got S=%h CO=%b, want S=%h CO=1",
                 ta[i], tb[i], tc[i], S, CO, ts[i]);
      end
      $display("chain: %h + %h + %b -> S=%h CO=%b", ta[i], tb[i], tc[i], S, CO);
    end
  endtask

  task automatic test_group_boundary();
    logic [15:0] ta [5] = '{16'h000F, 16'h0FFF, 16'h8000, 16'h00FF, 16'h0000};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h0001, 16'h0000};
    logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ts [5] = '{16'h0010, 16'h1000, 16'h0000, 16'h0100, 16'h0001};
    logic        tco[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; CI = tc[i];
      step();
      n_vec++;
      if (S !== ts[i] || CO !== tco[i]) begin
        n_err++;
        $display("FAIL group_boundary %h+%h+%b: got S=%h CO=%b, want S=%h CO=%b",
                 ta[i], tb[i], tc[i], S, CO, ts[i], tco[i]);
      end
      $display("group: %h + %h + %b -> S=%h CO=%b", ta[i], tb[i], tc[i], S, CO);
    end
  endtask

  // Outputs must not follow input or rst_n changes between edges.
  task automatic test_hold();
    A = 16'h1111; B = 16'h2222; CI = 1'b0;
    step();
    A = 16'hFFFF; B = 16'h0001; CI = 1'b1;
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (S !== 16'h3333 || CO !== 1'b0) begin
      n_err++;
      $display("FAIL hold_between_edges: got S=%h CO=%b, want S=3333 CO=0", S, CO);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (S !== 16'h0001 || CO !== 1'b1) begin
      n_err++;
      $display("FAIL hold_next_edge: got S=%h CO=%b, want S=0001 CO=1", S, CO);
    end
    $display("hold: S=%h CO=%b after late input change", S, CO);
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    int          bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      A  = 16'($urandom);
      B  = 16'($urandom);
      CI = 1'($urandom);
      rst_n = (i == 500) ? 1'b0 : 1'b1;
      exp = (i == 500) ? 17'd0 : ({1'b0, A} + {1'b0, B} + {16'd0, CI});
      step();
      n_vec++;
      if ({CO, S} !== exp) begin
        n_err++;
        bad++;
        $display("FAIL back_to_back[%0d] %h+%h+%b rst_n=%b: got %h, want %h",
                 i, A, B, CI, rst_n, {CO, S}, exp);
      end
    end
    rst_n = 1'b1;
    $display("back_to_back: 1000 vectors, %0d bad", bad);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    A = 16'h0; B = 16'h0; CI = 1'b0;
    test_reset();
    test_small_sums();
    test_full_carry();
    test_group_boundary();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_16b.md
Name: cla_16b

Overview:
- 16-bit unsigned two-level carry-lookahead adder with carry-in and carry-out.
- Used as the fast add primitive in datapaths.
- Four 4-bit lookahead groups feed a second-level lookahead carry unit.
- Sum and carry-out are registered, giving one clock of latency.

Parameters:
- None. Width is fixed at 16 bits, organised as 4 groups of 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- CI  input  1  carry-in to bit 0
- A  input  16  addend, unsigned
- B  input  16  addend, unsigned
- S  output  16  registered sum, bits [15:0]
- CO  output  1  registered carry-out of bit 15

Behaviour:
- Arithmetic: {CO,S} = A + B + CI, exact as a 17-bit result. There is no overflow flag and no signed interpretation.
- Bit level: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i]; S[i] = p[i] ^ c[i]; c[0] = CI.
- Group level, for each 4-bit group k (bits 4k..4k+3):
  - Internal carries come from flattened lookahead equations, e.g. c1 = g0 | p0&c0 and c2 = g1 | p1&g0 | p1&p0&c0, and so on.
  - Group propagate PG = p3&p2&p1&p0.
  - Group generate GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Second level: c4, c8, c12 and c16 are computed directly from CI and the group PG/GG signals using the same flattened form.
  - No ripple between groups.
  - CO = c16.
- The critical path must not include a 16-stage ripple chain.
  - Carry depth: bit-level P/G, then group P/G, then second-level carry, then in-group carry, then sum XOR.
- Register stage: on each rising clk edge:
  - If rst_n = 0: S <= 16'h0000 and CO <= 0.
  - Else: S <= combinational sum and CO <= c16.
- Latency is exactly 1 cycle.
  - Inputs applied before edge N appear on S/CO after edge N.
  - Throughput is one addition per cycle with no handshake. Inputs are sampled every cycle.
- Reset:
  - Synchronous only. rst_n has no effect between edges.
  - Asserting rst_n mid-stream clears the outputs at the next edge, discarding that edge's result.
  - The first edge with rst_n = 1 captures the inputs present at that edge.
- Outputs hold their value between edges, regardless of input changes.
- Boundary cases:
  - All-propagate (A ^ B = 16'hFFFF) with CI = 1 must produce S = 0 and CO = 1 in one cycle.
  - CI = 1 with A = B = 0 gives S = 1 and CO = 0.
- No X propagation from internal nodes after reset; all registers have defined values.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with A = 16'h1234, B = 16'h1111, CI = 1 -> S = 0, CO = 0. Release rst_n -> next edge S = 16'h2346, CO = 0.
- Small sums, CI = 0, checked one cycle after apply:
  - 0+0 -> S = 0
  - 1+0 -> 1
  - 2+1 -> 3
  - 2+3 -> 5
  - 3+3 -> 6
  - 7+3 -> 10
  - 3+12 -> 15
  - 14+1 -> 15
  - 15+15 -> 30
  - CO = 0 for all of the above.
- Full carry chain:
  - A = 16'hFFFF, B = 0, CI = 1 -> S = 0, CO = 1.
  - A = 16'hFFFF, B = 16'h0001, CI = 0 -> S = 0, CO = 1.
  - A = 16'hFFFF, B = 16'hFFFF, CI = 1 -> S = 16'hFFFF, CO = 1.
- Group boundaries:
  - A = 16'h000F, B = 1 -> S = 16'h0010.
  - A = 16'h0FFF, B = 1 -> S = 16'h1000.
  - A = 16'h8000, B = 16'h8000 -> S = 0, CO = 1.
- Back-to-back: change inputs every cycle for 1000 random {A,B,CI}. Each output must equal the 17-bit reference A + B + CI from the previous cycle. Also assert rst_n low for one cycle mid-stream -> that cycle's output is 0, and the stream resumes correctly afterwards.
